// File: rtl/local_prediction.sv
// Local-history pattern table of saturating counters with an in-flight index FIFO for training.
// Optional LOCAL_PREDICTION_BYPASS_EN forwards the post-training counter on a same-cycle lookup collision.
module local_prediction #(
  parameter int unsigned HIST_W = 10,
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [HIST_W-1:0]        history_in,
  input  logic                     lookup_valid,
  output logic                     predict_taken,
  output logic [CTR_W-1:0]         predict_ctr,
  output logic                     ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     queue_full,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     underflow_err
);

  localparam int unsigned ENTRIES = 2 ** HIST_W;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q, state_d;
  logic [HIST_W-1:0]   sweep_q, sweep_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                underflow_q, underflow_d;

  logic [CTR_W-1:0]    table_q [ENTRIES];
  logic [HIST_W-1:0]   fifo_q  [DEPTH];

  logic                tbl_we;
  logic [HIST_W-1:0]   tbl_waddr;
  logic [CTR_W-1:0]    tbl_wdata;

  logic                push, pop, full;
  logic [HIST_W-1:0]   head_idx;
  logic [CTR_W-1:0]    head_ctr, head_upd, stored_ctr;

  assign ready    = (state_q == RUN);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign head_idx = fifo_q[rd_ptr_q];
  assign head_ctr = table_q[head_idx];
  assign pop      = resolve_valid && ready && (count_q != '0);
  assign push     = lookup_valid && ready && (!full || pop);

  always_comb begin
    head_upd = head_ctr;
    if (resolve_taken) begin
      if (head_ctr != '1) head_upd = head_ctr + CTR_W'(1);
    end else begin
      if (head_ctr != '0) head_upd = head_ctr - CTR_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    tbl_we      = 1'b0;
    tbl_waddr   = head_idx;
    tbl_wdata   = head_upd;
    case (state_q)
      INIT: begin
        tbl_we    = 1'b1;
        tbl_waddr = sweep_q;
        tbl_wdata = CTR_W'(1);
        sweep_d   = sweep_q + HIST_W'(1);
        if (sweep_q == '1) state_d = RUN;
      end
      RUN: begin
        if (pop) begin
          tbl_we   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (resolve_valid) begin
          underflow_d = 1'b1;
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (push && !pop) count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Table and FIFO storage carry no reset; the INIT sweep initialises the table.
  always_ff @(posedge clock) begin
    if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
    if (push) fifo_q[wr_ptr_q] <= history_in;
  end

  assign stored_ctr = table_q[history_in];

  always_comb begin
    predict_ctr = '0;
    if (ready) begin
`ifdef LOCAL_PREDICTION_BYPASS_EN
      if (pop && (history_in == head_idx)) predict_ctr = head_upd;
      else predict_ctr = stored_ctr;
`else
      predict_ctr = stored_ctr;
`endif
    end
  end

  assign predict_taken = predict_ctr[CTR_W-1];
  assign queue_full    = full;
  assign queue_count   = count_q;
  assign underflow_err = underflow_q;

endmodule

// File: doc/local_prediction.md
Name: local_prediction

Overview:
- Consumer end of the local history path in the Tournament predictor.
- Takes the 10-bit per-PC history pattern produced by the local history table and indexes a pattern table of 2-bit saturating counters to produce a taken/not-taken prediction.
- Holds the history index of each in-flight prediction in a small FIFO until the branch resolves, then trains the counter at that index.
- Its output feeds the tournament chooser.

Parameters:
- HIST_W, 10, history width; the pattern table has 2**HIST_W entries.
- CTR_W, 2, saturating counter width.
- DEPTH, 4, in-flight FIFO depth; power of two, >= 2.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- history_in  input  HIST_W  history pattern for the current lookup
- lookup_valid  input  1  the current lookup is a branch; record its index
- predict_taken  output  1  prediction: counter MSB at history_in
- predict_ctr  output  CTR_W  raw counter value at history_in
- ready  output  1  table initialised; lookups and resolves are accepted
- resolve_valid  input  1  oldest in-flight branch has resolved
- resolve_taken  input  1  outcome of that branch
- queue_full  output  1  FIFO holds DEPTH entries
- queue_count  output  $clog2(DEPTH)+1  FIFO occupancy
- underflow_err  output  1  sticky flag: a resolve arrived with the FIFO empty

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT, sweep pointer=0.
  - FIFO read/write pointers and count=0.
  - ready=0, queue_full=0, queue_count=0, underflow_err=0.
  - The table is not cleared asynchronously; the sweep clears it.
- State INIT:
  - Each cycle writes 2'b01 (weakly not-taken) to table[sweep_ptr], then increments the pointer.
  - After writing entry 2**HIST_W-1, goes to RUN on the next edge. The sweep takes 2**HIST_W cycles after reset release.
  - ready=0, predict_taken=0, predict_ctr=0.
  - lookup_valid and resolve_valid are ignored, with no FIFO change and no error.
- State RUN:
  - ready=1.
  - predict_taken and predict_ctr are combinational from table[history_in], with zero-cycle latency.
- Push: lookup_valid && ready && (!queue_full || pop this cycle) writes history_in at the write pointer on the clock edge.
  - lookup_valid while full with no pop is dropped; the prediction output is still driven.
- Pop/train: resolve_valid && ready && count>0 reads the head index h.
  - table[h] becomes min(ctr+1, 3) if resolve_taken, else max(ctr-1, 0).
  - The head pointer advances.
- resolve_valid && ready && count==0: no table write; underflow_err<=1, held until reset.
- Simultaneous push and pop: count is unchanged and both pointers advance. Legal when full and when count==1.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH; queue_full = (count==DEPTH).
- Same-cycle read/write collision (history_in == h while training): predict outputs show the pre-update counter unless the optional feature is enabled.
- Reset asserted mid-operation discards all in-flight entries and restarts the INIT sweep.

Optional Feature:
- Macro: LOCAL_PREDICTION_BYPASS_EN.
- Defined: on a same-cycle collision (history_in == h with a pop active), predict_ctr and predict_taken show the post-update counter value combinationally.
- Undefined: they show the stored (pre-update) value. No other behaviour differs.

Test Plan:
- Reset release, then hold lookup_valid=1 -> ready=0 and queue_count=0 for exactly 1024 cycles, then ready=1; predict_ctr=2'b01 for history_in=0, 512 and 1023.
- history_in=10'h155, push then resolve taken, repeated 3 times -> predict_ctr sequence 01,10,11,11 (saturates); predict_taken=1 after the first resolve.
- Push 4 entries (0x001..0x004), then a 5th push with no resolve -> queue_full=1 and the 5th is dropped; 4 resolves not-taken train 0x001..0x004 in order to 00; queue_count returns to 0.
- FIFO full with push and resolve in the same cycle -> queue_count stays 4 and the new index is trained after the remaining 3.
- resolve_valid with an empty FIFO in RUN -> underflow_err=1 and no counter changes; reset clears the flag.
- Collision: history_in=0x0AA equals the head, ctr=01, resolve taken -> predict_ctr=01 without the macro, 10 with LOCAL_PREDICTION_BYPASS_EN; reset pulse mid-run -> queue_count=0 and ready=0 immediately.
